mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for a single request/ready memory port.
// One access at a time; a timed-out access completes with an error flag.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m0_we,
  input  logic              m1_we,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_err,
  output logic              m1_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rw,
  output logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic              valid_q, valid_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              win;

  // With both requesting, the master not served last wins.
  always_comb begin
    if (m0_req && m1_req) win = ~last_q;
    else                  win = m1_req;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    err_d   = 2'b00;
    valid_d = valid_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_d = ACCESS;
          sel_d   = win;
          gnt_d   = win ? 2'b10 : 2'b01;
          valid_d = 1'b1;
          cnt_d   = 8'd1;
          we_d    = win ? m1_we : m0_we;
          rw_d    = ~(win ? m1_we : m0_we);
          addr_d  = win ? m1_addr : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
        end
      end
      ACCESS: begin
        if (mem_ready || cnt_q == TO) begin
          state_d = DONE;
          valid_d = 1'b0;
          rw_d    = 1'b1;
          cnt_d   = 8'd0;
          last_d  = sel_q;
          done_d  = sel_q ? 2'b10 : 2'b01;
          rdata_d = '0;
          if (mem_ready) begin
            if (!we_q) rdata_d = mem_rdata;
          end else begin
            err_d = sel_q ? 2'b10 : 2'b01;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      gnt_q   <= 2'b00;
      done_q  <= 2'b00;
      err_q   <= 2'b00;
      valid_q <= 1'b0;
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_done   = done_q[0];
  assign m1_done   = done_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rw    = rw_q;
  assign mem_valid = valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter; done pulses are checked
// against a queue of expected completions.
module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic        m0_gnt, m1_gnt;
  logic        m0_done, m1_done;
  logic        m0_err, m1_err;
  logic [31:0] rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_rw, mem_valid;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  typedef struct {
    logic        m;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(15)
  ) dut (
    .clock(clk), .reset(rst_n),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rw(mem_rw), .mem_valid(mem_valid),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard pop and mutual-exclusion check.
  always @(negedge clk) begin
    exp_t e;
    if ({m0_gnt, m0_done, m0_err} != 3'b000 &&
        {m1_gnt, m1_done, m1_err} != 3'b000) begin
      checks++;
      errors++;
      $display("FAIL exclusive gnt=%b%b done=%b%b err=%b%b",
               m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err);
    end
    if (m0_done || m1_done) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done done=%b%b",
                 m1_done, m0_done);
      end else begin
        e = sbq.pop_front();
        if ({m1_done, m0_done} !== (e.m ? 2'b10 : 2'b01) ||
            {m1_err, m0_err} !==
              (e.err ? (e.m ? 2'b10 : 2'b01) : 2'b00) ||
            rdata !== e.rdata) begin
          errors++;
          $display("FAIL sb_done got done=%b%b err=%b%b rdata=%h exp m%0d err=%b rdata=%h",
                   m1_done, m0_done, m1_err, m0_err, rdata,
                   e.m, e.err, e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic m, input logic [31:0] d,
                      input logic err);
    exp_t e;
    e.m = m;
    e.rdata = d;
    e.err = err;
    sbq.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err,
         mem_valid, mem_rw} !== 8'b0000_0001) begin
      errors++;
      $display("FAIL reset_ctrl got %b%b%b%b%b%b%b%b exp 00000001",
               m1_gnt, m0_gnt, m1_done, m0_done, m1_err, m0_err,
               mem_valid, mem_rw);
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h rdata=%h exp 0",
               mem_addr, mem_wdata, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    m0_req = 1'b1;
    m0_addr = 32'h100;
    m0_we = 1'b0;
    push(1'b0, 32'hDEADBEEF, 1'b0);
    tick();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || mem_valid !== 1'b1 ||
        mem_rw !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL read_grant gnt=%b%b valid=%b rw=%b addr=%h exp 01 1 1 100",
               m1_gnt, m0_gnt, mem_valid, mem_rw, mem_addr);
    end
    tick();
    checks++;
    if (m0_gnt !== 1'b0 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_gnt_pulse gnt=%b valid=%b exp 0 1",
               m0_gnt, mem_valid);
    end
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ready = 1'b0;
    m0_req = 1'b0;
    checks++;
    if (m0_done !== 1'b1 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_done done=%b valid=%b exp 1 0",
               m0_done, mem_valid);
    end
    tick();
    checks++;
    if (m0_done !== 1'b0) begin
      errors++;
      $display("FAIL read_done_pulse done=%b exp 0", m0_done);
    end
  endtask

  task automatic test_round_robin();
    int n;
    apply_reset();
    m0_addr = 32'h1000;
    m1_addr = 32'h2000;
    m0_we = 1'b0;
    m1_we = 1'b0;
    for (int i = 0; i < 6; i++)
      push(i[0], 32'hA000_0000 + i, 1'b0);
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      n = 0;
      tick();
      while (!(m0_gnt || m1_gnt) && n < 10) begin
        tick();
        n++;
      end
      checks++;
      if ({m1_gnt, m0_gnt} !== (i[0] ? 2'b10 : 2'b01) ||
          mem_addr !== (i[0] ? 32'h2000 : 32'h1000)) begin
        errors++;
        $display("FAIL rr_order round %0d gnt=%b%b addr=%h exp m%0d",
                 i, m1_gnt, m0_gnt, mem_addr, i[0]);
      end
      mem_rdata = 32'hA000_0000 + i;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tick();
      if (i == 5) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
      checks++;
      if (m0_gnt || m1_gnt || mem_valid) begin
        errors++;
        $display("FAIL rr_idle_gap round %0d gnt=%b%b valid=%b exp 00 0",
                 i, m1_gnt, m0_gnt, mem_valid);
      end
    end
  endtask

  task automatic test_write();
    m1_req = 1'b1;
    m1_addr = 32'h20;
    m1_wdata = 32'h12345678;
    m1_we = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    push(1'b1, 32'h0, 1'b0);
    tick();
    m1_addr = 32'hBAD0;
    m1_wdata = 32'hBAD1;
    m1_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_rw !== 1'b0 ||
          mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
        errors++;
        $display("FAIL write_hold cyc %0d valid=%b rw=%b addr=%h wdata=%h exp 1 0 20 12345678",
                 i, mem_valid, mem_rw, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    m1_req = 1'b0;
    checks++;
    if (m1_done !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_done done=%b rdata=%h exp 1 0",
               m1_done, rdata);
    end
    tick();
  endtask

  task automatic test_timeout();
    int n;
    m0_req = 1'b1;
    m0_addr = 32'h300;
    m0_we = 1'b0;
    mem_rdata = 32'h5555_AAAA;
    push(1'b0, 32'h0, 1'b1);
    n = 0;
    tick();
    while (mem_valid && n < 40) begin
      n++;
      tick();
    end
    m0_req = 1'b0;
    checks++;
    if (n != 15 || m0_done !== 1'b1 || m0_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_len cycles=%0d done=%b err=%b exp 15 1 1",
               n, m0_done, m0_err);
    end
    tick();
    checks++;
    if (mem_valid || m0_done || m0_err || m0_gnt) begin
      errors++;
      $display("FAIL timeout_idle valid=%b done=%b err=%b gnt=%b exp 0",
               mem_valid, m0_done, m0_err, m0_gnt);
    end
  endtask

  task automatic test_reset_mid();
    m1_req = 1'b1;
    m1_addr = 32'h44;
    m1_wdata = 32'h77;
    m1_we = 1'b1;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || mem_rw !== 1'b1 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0 || m1_gnt) begin
      errors++;
      $display("FAIL reset_mid valid=%b rw=%b addr=%h wdata=%h exp 0 1 0 0",
               mem_valid, mem_rw, mem_addr, mem_wdata);
    end
    m1_req = 1'b0;
    m1_we = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    m0_req = 1'b1;
    m1_req = 1'b1;
    m0_addr = 32'h400;
    m0_we = 1'b0;
    push(1'b0, 32'h0000_0400, 1'b0);
    tick();
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b01 || mem_addr !== 32'h400) begin
      errors++;
      $display("FAIL reset_regrant gnt=%b%b addr=%h exp 01 400",
               m1_gnt, m0_gnt, mem_addr);
    end
    m1_req = 1'b0;
    mem_rdata = 32'h0000_0400;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    m0_req = 1'b0;
    tick();
  endtask

  task automatic test_drop_req();
    mem_ready = 1'b1;
    mem_rdata = 32'h1111_1111;
    tick();
    mem_ready = 1'b0;
    checks++;
    if (mem_valid || m0_gnt || m1_gnt || m0_done || m1_done) begin
      errors++;
      $display("FAIL stray_ready valid=%b gnt=%b%b done=%b%b exp 0",
               mem_valid, m1_gnt, m0_gnt, m1_done, m0_done);
    end
    m0_req = 1'b1;
    m0_addr = 32'h500;
    m0_we = 1'b0;
    push(1'b0, 32'hCAFEF00D, 1'b0);
    tick();
    m0_req = 1'b0;
    tick();
    tick();
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h500) begin
      errors++;
      $display("FAIL drop_req_hold valid=%b addr=%h exp 1 500",
               mem_valid, mem_addr);
    end
    mem_rdata = 32'hCAFEF00D;
    mem_ready = 1'b1;
    tick();
    checks++;
    if (m0_done !== 1'b1) begin
      errors++;
      $display("FAIL drop_req_done done=%b exp 1", m0_done);
    end
    tick();
    tick();
    mem_ready = 1'b0;
    checks++;
    if (mem_valid || m0_gnt || m0_done) begin
      errors++;
      $display("FAIL stray_after valid=%b gnt=%b done=%b exp 0",
               mem_valid, m0_gnt, m0_done);
    end
  endtask

  initial begin
    m0_req = 1'b0;
    m1_req = 1'b0;
    m0_addr = '0;
    m1_addr = '0;
    m0_wdata = '0;
    m1_wdata = '0;
    m0_we = 1'b0;
    m1_we = 1'b0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_timeout();
    test_reset_mid();
    test_drop_req();
    repeat (3) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d exp 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
